// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction ROM.
// Receives a length-prefixed byte image (len[7:0], len[15:8], then len x 4 data bytes,
// little-endian per word), assembles 32-bit words and writes them to the ROM from word
// address 0 upwards. The CPU is held while loading; completion and errors are reported.
//
// Ports:
//   clock        - system clock, rising edge
//   reset        - asynchronous, active-high
//   load_start   - one-cycle pulse, begins or restarts a load
//   rx_data      - incoming byte
//   rx_valid     - rx_data valid this cycle (no backpressure)
//   rom_wea      - ROM write enable, one pulse per word
//   rom_addra    - ROM word address
//   rom_dina     - ROM write data
//   cpu_hold     - holds the CPU while a load is in progress or has failed
//   busy         - load in progress
//   done         - one-cycle pulse on successful completion
//   err          - sticky error flag, cleared by load_start or reset
//   words_loaded - words written in the current load
module prog_loader #(
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned DEPTH          = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned TO_W           = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rom_wea,
    output logic [ADDR_W-1:0] rom_addra,
    output logic [31:0]       rom_dina,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       word_q, word_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              rom_wea_q, rom_wea_d;
    logic [ADDR_W-1:0] rom_addra_q, rom_addra_d;
    logic [31:0]       rom_dina_q, rom_dina_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [15:0]       words_q, words_d;

    logic              in_stream;
    logic              timeout;
    logic              go_err;
    logic [TO_W-1:0]   to_next;
    logic [15:0]       len_full;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        word_d      = word_q;
        to_cnt_d    = to_cnt_q;
        rom_wea_d   = 1'b0;
        rom_addra_d = rom_addra_q;
        rom_dina_d  = rom_dina_q;
        cpu_hold_d  = cpu_hold_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        words_d     = words_q;
        go_err      = 1'b0;
        len_full    = {rx_data, len_q[7:0]};

        in_stream = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
        to_next   = to_cnt_q + TO_W'(1);
        timeout   = in_stream && !rx_valid && (to_next == TO_W'(TIMEOUT_CYCLES));
        if (in_stream) begin
            to_cnt_d = rx_valid ? '0 : to_next;
        end

        // Commit the write issued last cycle; this also lets a pending write
        // finish on the same edge that a timeout moves us to StErr.
        if (rom_wea_q) begin
            rom_addra_d = rom_addra_q + ADDR_W'(1);
            words_d     = words_q + 16'd1;
        end

        if (load_start) begin
            // Restart wins over a simultaneous byte, which is dropped.
            state_d     = StLenLo;
            cpu_hold_d  = 1'b1;
            busy_d      = 1'b1;
            err_d       = 1'b0;
            words_d     = '0;
            rom_addra_d = '0;
            to_cnt_d    = '0;
            byte_idx_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StLenLo: begin
                    if (rx_valid) begin
                        len_d[7:0] = rx_data;
                        state_d    = StLenHi;
                    end else if (timeout) begin
                        go_err = 1'b1;
                    end
                end
                StLenHi: begin
                    if (rx_valid) begin
                        len_d = len_full;
                        if (len_full == 16'd0) begin
                            state_d = StDone;
                        end else if (32'(len_full) > DEPTH) begin
                            go_err = 1'b1;
                        end else begin
                            state_d    = StData;
                            byte_idx_d = '0;
                        end
                    end else if (timeout) begin
                        go_err = 1'b1;
                    end
                end
                StData: begin
                    if (rx_valid) begin
                        word_d[8*byte_idx_q +: 8] = rx_data;
                        byte_idx_d                = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            rom_wea_d  = 1'b1;
                            rom_dina_d = {rx_data, word_q[23:0]};
                        end
                    end
                    if (rom_wea_q && (words_q + 16'd1 == len_q)) begin
                        state_d = StDone;
                    end else if (timeout) begin
                        go_err = 1'b1;
                    end
                end
                StDone: begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end
                StErr: ;
                default: state_d = StIdle;
            endcase
        end

        // cpu_hold is left asserted so a partial program never runs.
        if (go_err) begin
            state_d = StErr;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            len_q       <= '0;
            byte_idx_q  <= '0;
            word_q      <= '0;
            to_cnt_q    <= '0;
            rom_wea_q   <= 1'b0;
            rom_addra_q <= '0;
            rom_dina_q  <= '0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            to_cnt_q    <= to_cnt_d;
            rom_wea_q   <= rom_wea_d;
            rom_addra_q <= rom_addra_d;
            rom_dina_q  <= rom_dina_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            words_q     <= words_d;
        end
    end

    assign rom_wea      = rom_wea_q;
    assign rom_addra    = rom_addra_q;
    assign rom_dina     = rom_dina_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DEPTH  = 16384;
    localparam int unsigned TMO    = 100;
    localparam int unsigned TO_W   = 7;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rom_wea;
    logic [ADDR_W-1:0] rom_addra;
    logic [31:0]       rom_dina;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       words_loaded;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [45:0] got_q[$];
    logic [45:0] exp_q[$];

    prog_loader #(
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO),
        .TO_W           (TO_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .load_start   (load_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rom_wea      (rom_wea),
        .rom_addra    (rom_addra),
        .rom_dina     (rom_dina),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    // Observe the ROM write port and done pulses mid-cycle.
    always @(negedge clock) begin
        if (rom_wea === 1'b1) got_q.push_back({rom_addra, rom_dina});
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pulse();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = $urandom_range(0, 255);
    endtask

    task automatic send_all(input logic [7:0] bq[$], input int max_gap);
        foreach (bq[i]) begin
            send(bq[i]);
            repeat ($urandom_range(0, max_gap)) tick();
        end
    endtask

    // Reference: the image's word list, straight from the stream format.
    task automatic build_exp(input logic [7:0] bq[$]);
        int unsigned len;
        exp_q.delete();
        len = {bq[1], bq[0]};
        if (len != 0 && len <= DEPTH) begin
            for (int unsigned w = 0; w < len; w++) begin
                if (4 * w + 5 < bq.size()) begin
                    exp_q.push_back({w[13:0], bq[4*w+5], bq[4*w+4], bq[4*w+3], bq[4*w+2]});
                end
            end
        end
    endtask

    task automatic make_image(input int unsigned len, output logic [7:0] bq[$]);
        logic [15:0] l;
        bq.delete();
        l = len[15:0];
        bq.push_back(l[7:0]);
        bq.push_back(l[15:8]);
        for (int unsigned i = 0; i < 4 * len; i++) bq.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_done(input string name, input int start_cnt, input int budget);
        for (int i = 0; i < budget && done_cnt == start_cnt; i++) tick();
        n_cmp++;
        if (done_cnt !== start_cnt + 1) begin
            n_bad++;
            $display("FAIL %s done_pulses: got %0d, need 1", name, done_cnt - start_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #2;
        n_cmp++; if (rom_wea !== 1'b0) begin n_bad++; $display("FAIL reset rom_wea: got %b need 0", rom_wea); end
        n_cmp++; if (rom_addra !== '0) begin n_bad++; $display("FAIL reset rom_addra: got %0h need 0", rom_addra); end
        n_cmp++; if (rom_dina !== 32'h0) begin n_bad++; $display("FAIL reset rom_dina: got %h need 0", rom_dina); end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL reset cpu_hold: got %b need 0", cpu_hold); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %b need 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b need 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %b need 0", err); end
        n_cmp++; if (words_loaded !== 16'h0) begin n_bad++; $display("FAIL reset words: got %0d need 0", words_loaded); end
        tick();
        reset = 1'b0;
        // Bytes in IDLE are ignored.
        got_q.delete();
        for (int i = 0; i < 6; i++) send(8'hA5);
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_ignore busy: got %b need 0", busy); end
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL idle_ignore writes: got %0d need 0", got_q.size()); end
    endtask

    task automatic test_basic();
        logic [7:0] bq[$];
        int d0;
        bq = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        got_q.delete();
        exp_q.delete();
        exp_q.push_back({14'd0, 32'h12345678});
        exp_q.push_back({14'd1, 32'hDEADBEEF});
        d0 = done_cnt;
        start_pulse();
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL basic hold_start: got %b need 1", cpu_hold); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic busy_start: got %b need 1", busy); end
        send_all(bq, 0);
        wait_done("basic", d0, 10);
        tick();
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL basic writes: got %0d words need %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL basic write%0d: got %h need %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL basic hold_end: got %b need 0", cpu_hold); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic busy_end: got %b need 0", busy); end
        n_cmp++; if (words_loaded !== 16'd2) begin n_bad++; $display("FAIL basic words: got %0d need 2", words_loaded); end
        n_cmp++; if (rom_addra !== 14'd2) begin n_bad++; $display("FAIL basic addr: got %0d need 2", rom_addra); end
    endtask

    task automatic test_zero_len();
        got_q.delete();
        start_pulse();
        send(8'h00);
        send(8'h00);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero done_early: got %b need 0", done); end
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero done_pulse: got %b need 1", done); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero done_width: got %b need 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL zero err: got %b need 0", err); end
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL zero writes: got %0d need 0", got_q.size()); end
    endtask

    task automatic test_overflow();
        got_q.delete();
        start_pulse();
        send(8'h01);
        send(8'h40);
        for (int i = 0; i < 8; i++) send(8'h5A);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf err: got %b need 1", err); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL ovf hold: got %b need 1", cpu_hold); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf busy: got %b need 0", busy); end
        n_cmp++; if (got_q.size() !== 0) begin n_bad++; $display("FAIL ovf writes: got %0d need 0", got_q.size()); end
        start_pulse();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf err_clear: got %b need 0", err); end
        // len == DEPTH is the largest accepted length.
        send(8'h00);
        send(8'h40);
        tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ovf depth_ok: got %b need 0", err); end
    endtask

    task automatic test_timeout();
        logic [7:0] bq[$];
        int d0;
        make_image(2, bq);
        build_exp(bq);
        got_q.delete();
        d0 = done_cnt;
        start_pulse();
        foreach (bq[i]) begin
            send(bq[i]);
            repeat (50) tick();
        end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL gap50 err: got %b need 0", err); end
        n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL gap50 done: got %0d need 1", done_cnt - d0); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL gap50 writes: got %0d words need %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL gap50 write%0d: got %h need %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        // Stall after the fifth data byte.
        got_q.delete();
        start_pulse();
        for (int i = 0; i < 7; i++) send(bq[i]);
        repeat (TMO - 1) tick();
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL tmo err_early: got %b need 0", err); end
        tick();
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tmo err: got %b need 1", err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo busy: got %b need 0", busy); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL tmo hold: got %b need 1", cpu_hold); end
        n_cmp++; if (words_loaded !== 16'd1) begin n_bad++; $display("FAIL tmo words: got %0d need 1", words_loaded); end
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL tmo writes: got %0d need 1", got_q.size()); end
    endtask

    task automatic test_restart();
        logic [7:0] bq[$];
        int d0;
        got_q.delete();
        start_pulse();
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB); send(8'hCC);
        // Restart with a colliding byte that must be dropped.
        load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        tick();
        load_start = 1'b0; rx_valid = 1'b0;
        bq = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        d0 = done_cnt;
        send_all(bq, 0);
        wait_done("restart", d0, 10);
        n_cmp++;
        if (got_q.size() !== 1) begin
            n_bad++; $display("FAIL restart writes: got %0d words need 1", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0] !== {14'd0, 32'h44332211}) begin
                n_bad++; $display("FAIL restart word: got %h need %h", got_q[0], {14'd0, 32'h44332211});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] bq[$];
        int d0;
        for (int it = 0; it < 6; it++) begin
            make_image($urandom_range(1, 6), bq);
            build_exp(bq);
            got_q.delete();
            d0 = done_cnt;
            start_pulse();
            send_all(bq, (it % 2 == 0) ? 0 : 3);
            wait_done("random", d0, 10);
            n_cmp++;
            if (got_q.size() !== exp_q.size()) begin
                n_bad++; $display("FAIL random%0d writes: got %0d need %0d", it, got_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    n_cmp++;
                    if (got_q[i] !== exp_q[i]) begin
                        n_bad++; $display("FAIL random%0d write%0d: got %h need %h", it, i, got_q[i], exp_q[i]);
                    end
                end
            end
            n_cmp++;
            if (words_loaded !== 16'(exp_q.size())) begin
                n_bad++; $display("FAIL random%0d words: got %0d need %0d", it, words_loaded, exp_q.size());
            end
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL random%0d err: got %b need 0", it, err); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] bq[$];
        int d0;
        make_image(2, bq);
        start_pulse();
        for (int i = 0; i < 8; i++) send(bq[i]);
        n_cmp++; if (words_loaded !== 16'd1) begin n_bad++; $display("FAIL arst words_pre: got %0d need 1", words_loaded); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (cpu_hold !== 1'b0) begin n_bad++; $display("FAIL arst hold: got %b need 0", cpu_hold); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst busy: got %b need 0", busy); end
        n_cmp++; if (words_loaded !== 16'd0) begin n_bad++; $display("FAIL arst words: got %0d need 0", words_loaded); end
        n_cmp++; if (rom_addra !== '0) begin n_bad++; $display("FAIL arst addr: got %0d need 0", rom_addra); end
        n_cmp++; if (rom_dina !== 32'h0) begin n_bad++; $display("FAIL arst dina: got %h need 0", rom_dina); end
        #2 reset = 1'b0;
        tick();
        make_image(3, bq);
        build_exp(bq);
        got_q.delete();
        d0 = done_cnt;
        start_pulse();
        send_all(bq, 1);
        wait_done("arst_reload", d0, 10);
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_bad++; $display("FAIL arst_reload writes: got %0d need %0d", got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL arst_reload write%0d: got %h need %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_timeout();
        test_restart();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction ROM. The fetch unit only reads `prgrom` at PC[15:2]; this block fills the ROM's write port from a byte stream (UART/debug link), so programs load without resynthesis.
- Accepts a length-prefixed image, assembles 32-bit words and writes them sequentially from word address 0.
- Holds the CPU while loading and reports done or error.

Parameters:
- ADDR_W, 14, ROM word-address width (matches `addra[13:0]`).
- DEPTH, 16384, ROM capacity in words.
- TIMEOUT_CYCLES, 1000000, idle cycles between bytes before a load aborts.
- TO_W, 20, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clock, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- load_start, in, 1: one-cycle pulse that begins or restarts a load.
- rx_data, in, 8: incoming byte.
- rx_valid, in, 1: rx_data valid this cycle. No backpressure; one byte is accepted per cycle when valid.
- rom_wea, out, 1: ROM write enable, one-cycle pulse per word.
- rom_addra, out, ADDR_W: ROM word address.
- rom_dina, out, 32: ROM write data.
- cpu_hold, out, 1: holds the CPU in reset / stops the PC.
- busy, out, 1: load in progress.
- done, out, 1: one-cycle pulse on successful completion.
- err, out, 1: sticky error flag; cleared by load_start or reset.
- words_loaded, out, 16: count of words written in the current load.

Behaviour:
- Reset (async): state IDLE.
  - rom_wea=0, rom_addra=0, rom_dina=0.
  - cpu_hold=0, busy=0, done=0, err=0, words_loaded=0.
  - Length, byte index and timeout counter all 0.
- Registers: all outputs are registered and update on the rising edge of clock.
- Stream format:
  - Byte 0 = len[7:0], byte 1 = len[15:8]; len is the word count.
  - Then len×4 data bytes, little-endian per word: first byte → bits[7:0], fourth byte → bits[31:24].
- IDLE:
  - rx_valid is ignored.
  - load_start → LEN_LO. Next cycle: cpu_hold=1, busy=1, err=0, words_loaded=0, rom_addra=0, timeout counter=0.
- LEN_LO: rx_valid → len[7:0]=rx_data → LEN_HI.
- LEN_HI: rx_valid → len[15:8]=rx_data, then:
  - len==0 → DONE.
  - len>DEPTH → ERR.
  - Otherwise → DATA with byte_idx=0.
- DATA:
  - Each rx_valid places rx_data into byte lane byte_idx of the assembly register and increments byte_idx modulo 4.
  - On acceptance of the byte with byte_idx==3, in the next cycle: rom_wea=1, rom_dina=assembled word, rom_addra=current word address.
  - The cycle after the write, rom_addra and words_loaded each increment by 1.
  - Bytes may keep arriving back-to-back during the write cycle without loss.
  - When words_loaded reaches len after that increment → DONE.
- DONE: one cycle.
  - done=1, cpu_hold=0, busy=0 → IDLE.
  - rom_addra and words_loaded keep their final values until the next load_start.
- ERR:
  - err=1, busy=0, cpu_hold stays 1 so a partial program never runs.
  - Remains in ERR until load_start (→ LEN_LO) or reset.
- Timeout:
  - In LEN_LO, LEN_HI and DATA the counter clears on every rx_valid and increments otherwise.
  - Reaching TIMEOUT_CYCLES → ERR.
  - A pending write (4th byte already accepted) still completes before ERR takes effect.
- load_start in any non-IDLE state restarts at LEN_LO with the same clears as from IDLE. load_start has priority over a simultaneous rx_valid; that byte is dropped.
- Address wrap cannot occur: len≤DEPTH is enforced, and rom_addra never exceeds len−1 while rom_wea=1.
- Reset mid-load: immediate return to IDLE with cpu_hold=0. The ROM contents are partial; the bench/host is responsible for reloading.

Test Plan:
- Basic load: reset, load_start, bytes 02 00 | 78 56 34 12 | EF BE AD DE back-to-back.
  - Expected: rom_wea pulses twice, at addr 0 with 0x12345678 and at addr 1 with 0xDEADBEEF.
  - Then done pulses once, cpu_hold falls, words_loaded=2.
- Zero length: bytes 00 00.
  - Expected: no rom_wea; done pulse two cycles after the second byte; err=0.
- Overflow: bytes 01 40 (len=16385).
  - Expected: ERR with err=1, cpu_hold=1, no rom_wea.
  - A following load_start clears err.
- Gapped stream plus timeout (TIMEOUT_CYCLES=100 in bench), bytes spaced 50 cycles apart:
  - Expected: load completes normally.
  - A 101-cycle gap after the 5th byte → err=1, only 1 word written, busy=0.
- Restart: load_start after 3 data bytes, then a fresh 01 00 11 22 33 44.
  - Expected: single write of 0x44332211 at addr 0; the stale partial bytes are not merged.
- Async reset asserted mid-DATA, between clock edges:
  - Expected: all outputs reach reset values immediately; cpu_hold=0; the next load_start behaves normally.
